div_issue_stage: RTL



---
 rtl/div_issue_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_issue_stage.sv
`default_nettype none
// ============================================================================
// div_issue_stage : FIFO-buffered valid/ready issue stage around a comb. divider
// Revision 1.0
// ============================================================================
module div_issue_stage #(
    parameter int W      = 4,
    parameter int DEPTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic [W-1:0]           div_a,
    output logic [W-1:0]           div_b,
    input  logic [W-1:0]           div_q,
    input  logic [W-1:0]           div_r,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_q,
    output logic [W-1:0]           out_r,
    output logic                   out_dz,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);
    localparam logic [SW-1:0] CNT_ONE     = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    state_t         state;
    logic [SW-1:0]  settle_cnt;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [2*W-1:0] mem [DEPTH];
    logic           push;
    logic           pop;
    logic           out_free;
    logic           capture;
    logic           fifo_empty;

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count < FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign out_free   = !out_valid || out_ready;
    assign capture    = out_free &&
                        (((state == ST_SETTLE) && (settle_cnt == CNT_ONE)) ||
                         (state == ST_STALL));
    // Pop only from registered occupancy, so a pair pushed this cycle waits one edge.
    assign pop        = !fifo_empty && ((state == ST_IDLE) || capture);
    assign busy       = !fifo_empty || (state != ST_IDLE) || out_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            div_a      <= '0;
            div_b      <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            out_r      <= '0;
            out_dz     <= 1'b0;
        end else begin
            if (pop) begin
                {div_a, div_b} <= mem[rd_ptr];
                settle_cnt     <= SETTLE_INIT;
            end else if ((state == ST_SETTLE) && (settle_cnt != CNT_ONE)) begin
                settle_cnt <= settle_cnt - CNT_ONE;
            end

            if (capture) begin
                out_valid <= 1'b1;
                if (div_b != '0) begin
                    out_q  <= div_q;
                    out_r  <= div_r;
                    out_dz <= 1'b0;
                end else begin
                    // Divider output is meaningless for b == 0; report saturated quotient.
                    out_q  <= '1;
                    out_r  <= div_a;
                    out_dz <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == CNT_ONE) begin
                        if (capture) begin
                            state <= pop ? ST_SETTLE : ST_IDLE;
                        end else begin
                            state <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (capture) begin
                        state <= pop ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
